inference_sequencer: RTL and testbench
======================================

# inference_sequencer

Frame-level controller that sequences one inference of `full_system_top`. On `start` it streams a stored image from a synchronous pixel memory into the network as a contiguous `en`/`pixel_in` burst and waits for `valid_out`. It then captures `class_scores`, runs a sequential signed argmax, and reports the predicted class, its score and the busy-cycle count. It sits between the host/frame-buffer side and the CNN top, replacing bench-driven pixel streaming.

## Interface
Parameters:
- DATA_WIDTH, 16, pixel and score width (scores signed, Q8.8)
- NUM_CLASSES, 15, number of class scores
- NUM_PIXELS, 50176, pixels per frame (224×224)
- TIMEOUT_CYCLES, 2000000, maximum WAIT cycles before abort
- ADDR_W, $clog2(NUM_PIXELS), pixel memory address width
- CLS_W, $clog2(NUM_CLASSES), class index width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin one inference; sampled only in IDLE
- busy  out  1  high in STREAM, WAIT and ARGMAX
- mem_rd_en  out  1  pixel memory read strobe
- mem_addr  out  ADDR_W  pixel memory address
- mem_rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en
- nn_en  out  1  drives CNN `en`
- nn_pixel  out  DATA_WIDTH  drives CNN `pixel_in`
- nn_scores  in  NUM_CLASSES*DATA_WIDTH  CNN `class_scores`; class i at [i*DATA_WIDTH +: DATA_WIDTH]
- nn_valid  in  1  CNN `valid_out`
- done  out  1  one-cycle completion pulse
- timeout  out  1  sticky flag for the last run: result is a timeout
- pred_class  out  CLS_W  argmax index
- pred_score  out  DATA_WIDTH  signed maximum score
- cycle_count  out  32  busy cycles of the last run

## Operation
- States: IDLE, STREAM, WAIT, ARGMAX, DONE.
- **IDLE**
  - `start`=1 → STREAM.
  - Clears `timeout` and the internal cycle counter.
  - `pred_class`, `pred_score` and `cycle_count` hold their previous values.
- **STREAM**
  - `mem_rd_en`=1 and `mem_addr` = 0, 1, …, NUM_PIXELS−1 over NUM_PIXELS consecutive cycles, then → WAIT.
  - `nn_en`/`nn_pixel` are registered copies of `mem_rd_en`/`mem_rd_data`: a delay of exactly 1 cycle, so the burst is NUM_PIXELS contiguous cycles with no gaps.
- **WAIT**
  - `nn_valid`=1 → capture all `nn_scores` into a register array, then → ARGMAX.
  - If the wait counter reaches TIMEOUT_CYCLES → DONE with `timeout`=1, `pred_class`=0, `pred_score`=0.
  - `nn_valid` seen during STREAM is ignored.
- **ARGMAX**
  - Initialise max = score[0], idx = 0.
  - Compare score[1..NUM_CLASSES−1], one class per cycle: NUM_CLASSES−1 cycles, then → DONE.
  - Comparison is signed and strictly greater-than, so ties keep the lowest index.
- **DONE**
  - `done`=1 for exactly one cycle.
  - `pred_class`, `pred_score` and `cycle_count` are updated in this cycle and valid while `done`=1.
  - → IDLE.
- The cycle counter increments on every cycle with `busy`=1 and saturates at 2^32−1.
- `start` outside IDLE is ignored; there is no queueing.
- Reset in any state:
  - Next state is IDLE.
  - All outputs go to 0: `busy`, `done`, `timeout`, `nn_en`, `nn_pixel`, `mem_rd_en`, `mem_addr`, `pred_class`, `pred_score`, `cycle_count`.
  - Any in-flight burst is cut off immediately: `nn_en` drops asynchronously.

## Timing
- `start` sampled high at edge E0:
  - `mem_rd_en`=1 during cycles E0+1 … E0+NUM_PIXELS.
  - `nn_en`=1 during cycles E0+2 … E0+NUM_PIXELS+1.
- WAIT begins at cycle E0+NUM_PIXELS+1. That cycle also carries the last `nn_en`.
- `nn_valid` first sampled high at edge V:
  - ARGMAX spans cycles V+1 … V+NUM_CLASSES−1.
  - `done` is high in cycle V+NUM_CLASSES.
- `cycle_count` = NUM_PIXELS + (WAIT cycles including the capture cycle) + NUM_CLASSES − 1.
- `busy` is low in the `done` cycle.
- A new `start` is accepted in the first IDLE cycle, 1 cycle after `done`.
- Timeout: `done` falls in the cycle after WAIT has lasted TIMEOUT_CYCLES cycles.

## Test plan
Parameters for all scenarios unless stated: NUM_PIXELS=16, TIMEOUT_CYCLES=64, memory word = 0x1000+addr.

1. Basic run.
   - Stimulus: `start`; the model raises `nn_valid` 10 cycles after the last `nn_en`; score[7]=0x0300, all others 0x0100.
   - Required: `nn_pixel` = 0x1000 … 0x100F on 16 contiguous `nn_en` cycles; `done` once; `pred_class`=7; `pred_score`=0x0300; `cycle_count`=16+11+14=41.
2. Signed scores and ties.
   - Stimulus: all scores negative; score[3]=score[9]=0xFF80 (−0.5), the maximum.
   - Required: `pred_class`=3, `pred_score`=0xFF80.
3. Timeout.
   - Stimulus: `nn_valid` never asserted.
   - Required: `done` with `timeout`=1, `pred_class`=0, `pred_score`=0, `cycle_count`=16+64=80.
4. Start while busy.
   - Stimulus: pulse `start` mid-STREAM and again in ARGMAX.
   - Required: exactly one burst and one `done`; `mem_addr` sequence uninterrupted.
5. Reset mid-STREAM.
   - Stimulus: assert `rst` at address 8; release; `start` again.
   - Required: all outputs 0 during reset; second run streams from address 0 and completes normally.
6. Back-to-back runs.
   - Stimulus: `start` held high continuously.
   - Required: the second burst's `mem_rd_en` rises 2 cycles after the first `done`; results of the first run are held until the second `done`.

Source files
------------

// File: rtl/inference_sequencer.sv
// inference_sequencer: streams one stored frame into the CNN, waits for its
// scores, runs a sequential signed argmax and reports class, score and the
// number of busy cycles. Control registers reset asynchronously; the captured
// score array and running maximum are plain data registers.
module inference_sequencer #(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_CLASSES    = 15,
    parameter int NUM_PIXELS     = 50176,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int ADDR_W         = $clog2(NUM_PIXELS),
    parameter int CLS_W          = $clog2(NUM_CLASSES)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              busy,
    output logic                              mem_rd_en,
    output logic [ADDR_W-1:0]                 mem_addr,
    input  logic [DATA_WIDTH-1:0]             mem_rd_data,
    output logic                              nn_en,
    output logic [DATA_WIDTH-1:0]             nn_pixel,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0] nn_scores,
    input  logic                              nn_valid,
    output logic                              done,
    output logic                              timeout,
    output logic [CLS_W-1:0]                  pred_class,
    output logic [DATA_WIDTH-1:0]             pred_score,
    output logic [31:0]                       cycle_count
);

    localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [CLS_W-1:0]  LAST_CLS  = CLS_W'(NUM_CLASSES - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT,
        S_ARGMAX,
        S_DONE
    } state_t;

    state_t                       r_state;
    state_t                       w_state_next;
    logic [ADDR_W-1:0]            r_addr;
    logic [WAIT_W-1:0]            r_wait;
    logic [CLS_W-1:0]             r_cls;
    logic [31:0]                  r_cnt;
    logic                         r_nn_en;
    logic signed [DATA_WIDTH-1:0] r_score [NUM_CLASSES];
    logic signed [DATA_WIDTH-1:0] r_max;
    logic [CLS_W-1:0]             r_idx;
    logic                         r_timeout;
    logic [CLS_W-1:0]             r_pred_class;
    logic [DATA_WIDTH-1:0]        r_pred_score;
    logic [31:0]                  r_cycle_count;

    logic                         w_busy;
    logic                         w_capture;
    logic                         w_timeout_hit;
    logic                         w_argmax_last;
    logic signed [DATA_WIDTH-1:0] w_cand;
    logic signed [DATA_WIDTH-1:0] w_max_next;
    logic [CLS_W-1:0]             w_idx_next;

    // Saturating increment for the busy-cycle counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and state-decoded strobes.
    always_comb begin
        w_state_next  = r_state;
        w_busy        = 1'b0;
        w_capture     = 1'b0;
        w_timeout_hit = 1'b0;
        w_argmax_last = 1'b0;
        mem_rd_en     = 1'b0;
        done          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_STREAM;
            end
            S_STREAM: begin
                w_busy    = 1'b1;
                mem_rd_en = 1'b1;
                if (r_addr == LAST_ADDR) w_state_next = S_WAIT;
            end
            S_WAIT: begin
                w_busy = 1'b1;
                if (nn_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = S_ARGMAX;
                end else if (r_wait == LAST_WAIT) begin
                    w_timeout_hit = 1'b1;
                    w_state_next  = S_DONE;
                end
            end
            S_ARGMAX: begin
                w_busy = 1'b1;
                if (r_cls == LAST_CLS) begin
                    w_argmax_last = 1'b1;
                    w_state_next  = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // One argmax step: strict signed greater-than keeps the lowest index on ties.
    always_comb begin
        w_cand     = r_score[r_cls];
        w_max_next = r_max;
        w_idx_next = r_idx;
        if (w_cand > r_max) begin
            w_max_next = w_cand;
            w_idx_next = r_cls;
        end
    end

    // Address, wait and class counters, burst enable and busy-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wait  <= '0;
            r_cls   <= CLS_W'(1);
            r_cnt   <= '0;
            r_nn_en <= 1'b0;
        end else begin
            r_nn_en <= mem_rd_en;
            if (r_state == S_STREAM && r_addr != LAST_ADDR) r_addr <= r_addr + 1'b1;
            else                                            r_addr <= '0;
            if (r_state == S_WAIT) r_wait <= r_wait + 1'b1;
            else                   r_wait <= '0;
            if (r_state == S_ARGMAX) r_cls <= r_cls + 1'b1;
            else                     r_cls <= CLS_W'(1);
            if (w_busy)                  r_cnt <= sat_inc(r_cnt);
            else if (r_state == S_IDLE)  r_cnt <= '0;
        end
    end

    // Score capture and running maximum (data only, no reset needed).
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                r_score[i] <= nn_scores[i*DATA_WIDTH +: DATA_WIDTH];
            end
            r_max <= nn_scores[DATA_WIDTH-1:0];
            r_idx <= '0;
        end else if (r_state == S_ARGMAX) begin
            r_max <= w_max_next;
            r_idx <= w_idx_next;
        end
    end

    // Result registers: loaded on entry to DONE, held until the next DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timeout     <= 1'b0;
            r_pred_class  <= '0;
            r_pred_score  <= '0;
            r_cycle_count <= '0;
        end else begin
            if (r_state == S_IDLE && start) r_timeout <= 1'b0;
            if (w_timeout_hit) begin
                r_timeout     <= 1'b1;
                r_pred_class  <= '0;
                r_pred_score  <= '0;
                r_cycle_count <= sat_inc(r_cnt);
            end else if (w_argmax_last) begin
                r_pred_class  <= w_idx_next;
                r_pred_score  <= w_max_next;
                r_cycle_count <= sat_inc(r_cnt);
            end
        end
    end

    // The memory read register supplies the data delay; gating keeps the
    // pixel bus at zero outside the burst and during reset.
    assign busy        = w_busy;
    assign mem_addr    = r_addr;
    assign nn_en       = r_nn_en;
    assign nn_pixel    = r_nn_en ? mem_rd_data : '0;
    assign timeout     = r_timeout;
    assign pred_class  = r_pred_class;
    assign pred_score  = r_pred_score;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_inference_sequencer.sv
// Testbench for inference_sequencer: pixel memory and CNN responder models,
// a table of directed frames, randomized frames checked against an argmax
// reference, and hand-written start-while-busy, reset and back-to-back runs.
module tb_inference_sequencer;

    localparam int NP = 16;
    localparam int TO = 64;
    localparam int NC = 15;
    localparam int DW = 16;
    localparam int SW = NC * DW;
    localparam int AW = $clog2(NP);
    localparam int CW = $clog2(NC);

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data;
    logic          nn_en;
    logic [DW-1:0] nn_pixel;
    logic [SW-1:0] nn_scores;
    logic          nn_valid;
    logic          done;
    logic          timeout;
    logic [CW-1:0] pred_class;
    logic [DW-1:0] pred_score;
    logic [31:0]   cycle_count;

    int n_tests = 0;
    int n_fail  = 0;

    int          prev_cls = 0;
    logic [15:0] prev_sc  = '0;
    int          prev_cnt = 0;

    typedef struct {
        int            vdelay;
        logic [SW-1:0] sc;
        int            cls;
        logic [15:0]   score;
        bit            to;
        int            cnt;
    } vec_t;

    vec_t vt [6];

    inference_sequencer #(
        .DATA_WIDTH(DW), .NUM_CLASSES(NC), .NUM_PIXELS(NP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .nn_en(nn_en), .nn_pixel(nn_pixel), .nn_scores(nn_scores), .nn_valid(nn_valid),
        .done(done), .timeout(timeout), .pred_class(pred_class),
        .pred_score(pred_score), .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous pixel memory: word = 0x1000 + address, one cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= 16'h1000 + 16'(mem_addr);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] mk(input logic [15:0] base, input int ia, input logic [15:0] va,
                                         input int ib, input logic [15:0] vb);
        logic [SW-1:0] r;
        for (int i = 0; i < NC; i++) r[i*DW +: DW] = base;
        r[ia*DW +: DW] = va;
        r[ib*DW +: DW] = vb;
        return r;
    endfunction

    // Reference argmax: first index holding the largest signed value.
    function automatic void ref_argmax(input logic [SW-1:0] sc, output int cls, output logic [15:0] score);
        logic signed [15:0] best;
        logic signed [15:0] v;
        best = sc[15:0];
        cls  = 0;
        for (int i = 1; i < NC; i++) begin
            v = sc[i*DW +: DW];
            if (v > best) begin
                best = v;
                cls  = i;
            end
        end
        score = best;
    endfunction

    task automatic reset_chk(input string tag);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".timeout"}, timeout, 0);
        check({tag, ".nn_en"}, nn_en, 0);
        check({tag, ".nn_pixel"}, nn_pixel, 0);
        check({tag, ".mem_rd_en"}, mem_rd_en, 0);
        check({tag, ".mem_addr"}, mem_addr, 0);
        check({tag, ".pred_class"}, pred_class, 0);
        check({tag, ".pred_score"}, pred_score, 0);
        check({tag, ".cycle_count"}, cycle_count, 0);
    endtask

    task automatic idle_check(input string tag, input int n);
        int act = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (mem_rd_en || busy || done || nn_en) act++;
        end
        check({tag, ".idle_activity"}, act, 0);
    endtask

    // One frame. hold: 0 = pulse start, 1 = keep start high, 2 = keep high until done.
    // Expected values come from the caller; timing expectations from the frame rules.
    task automatic do_run(input string tag, input int vdelay, input logic [SW-1:0] sc, input int hold,
                          input bit spam, input bit early_v, input int exp_cls,
                          input logic [15:0] exp_sc, input bit exp_to, input int exp_cnt);
        int lat, k, n_rd, last_rd, n_en, first_en, last_en, since, busy_n;
        int bad_addr, bad_pix, bad_hold, done_k;
        bit got_done, busy_in_done, to_v;
        int cls_v, cnt_v;
        logic [15:0] sc_v;
        lat = 0; n_rd = 0; last_rd = -1; n_en = 0; first_en = -1; last_en = -1; since = 0;
        busy_n = 0; bad_addr = 0; bad_pix = 0; bad_hold = 0; done_k = -1;
        got_done = 0; busy_in_done = 1; to_v = 0; cls_v = -1; cnt_v = -1; sc_v = 'x;
        nn_scores = sc;
        start = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (hold == 0) start = 1'b0;
        end while (!mem_rd_en && lat < 8);
        check({tag, ".start_lat"}, lat, 1);
        k = 1;
        while (!got_done && k < 300) begin
            if (busy) busy_n++;
            if (mem_rd_en) begin
                if (mem_addr !== AW'(n_rd)) bad_addr++;
                n_rd++;
                last_rd = k;
            end
            if (nn_en) begin
                if (nn_pixel !== 16'h1000 + 16'(n_en)) bad_pix++;
                if (n_en == 0) first_en = k;
                n_en++;
                last_en = k;
                since = 0;
            end else if (n_en > 0) begin
                since++;
            end
            if (done) begin
                got_done     = 1;
                done_k       = k;
                busy_in_done = busy;
                to_v         = timeout;
                cls_v        = int'(pred_class);
                sc_v         = pred_score;
                cnt_v        = int'(cycle_count);
            end else begin
                if (pred_class !== CW'(prev_cls) || pred_score !== prev_sc || cycle_count !== 32'(prev_cnt))
                    bad_hold++;
                nn_valid = (vdelay >= 0 && n_en == NP && since == vdelay) || (early_v && k == 5);
                if (spam) start = (k == 6) || (k == NP + 1 + vdelay + 3);
                @(negedge clk);
                k++;
            end
        end
        nn_valid = 1'b0;
        if (hold != 1) start = 1'b0;
        check({tag, ".done_seen"}, got_done, 1);
        check({tag, ".done_cycle"}, done_k, exp_cnt + 1);
        check({tag, ".rd_count"}, n_rd, NP);
        check({tag, ".rd_last"}, last_rd, NP);
        check({tag, ".addr_seq_errs"}, bad_addr, 0);
        check({tag, ".en_count"}, n_en, NP);
        check({tag, ".en_first"}, first_en, 2);
        check({tag, ".en_last"}, last_en, NP + 1);
        check({tag, ".pixel_errs"}, bad_pix, 0);
        check({tag, ".held_results_errs"}, bad_hold, 0);
        check({tag, ".busy_cycles"}, busy_n, exp_cnt);
        check({tag, ".busy_in_done"}, busy_in_done, 0);
        check({tag, ".timeout"}, to_v, exp_to);
        check({tag, ".pred_class"}, cls_v, exp_cls);
        check({tag, ".pred_score"}, sc_v, exp_sc);
        check({tag, ".cycle_count"}, cnt_v, exp_cnt);
        @(negedge clk);
        check({tag, ".done_single"}, done, 0);
        check({tag, ".no_early_restart"}, mem_rd_en, 0);
        prev_cls = exp_cls;
        prev_sc  = exp_sc;
        prev_cnt = exp_cnt;
    endtask

    initial begin
        int          d, rc, rcnt;
        logic [15:0] rs;
        logic [SW-1:0] sc;
        logic [15:0] pal [4];
        bit          rto;

        pal[0] = 16'h8000; pal[1] = 16'hFFFF; pal[2] = 16'h0000; pal[3] = 16'h7FFF;

        vt[0] = '{10, mk(16'h0100, 7, 16'h0300, 7, 16'h0300), 7, 16'h0300, 1'b0, 41};
        vt[1] = '{5, mk(16'hFE00, 3, 16'hFF80, 9, 16'hFF80), 3, 16'hFF80, 1'b0, 36};
        vt[2] = '{-1, mk(16'h0100, 2, 16'h0500, 2, 16'h0500), 0, 16'h0000, 1'b1, 80};
        vt[3] = '{0, mk(16'h8000, 14, 16'h7FFF, 14, 16'h7FFF), 14, 16'h7FFF, 1'b0, 31};
        vt[4] = '{63, mk(16'h8000, 0, 16'h8000, 0, 16'h8000), 0, 16'h8000, 1'b0, 94};
        vt[5] = '{64, mk(16'h0100, 4, 16'h0200, 4, 16'h0200), 0, 16'h0000, 1'b1, 80};

        rst = 1'b1; start = 1'b0; nn_valid = 1'b0; nn_scores = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_chk("init");
        rst = 1'b0;
        @(negedge clk);

        // Directed frames
        for (int i = 0; i < 6; i++) begin
            do_run($sformatf("vec%0d", i), vt[i].vdelay, vt[i].sc, 0, 1'b0, 1'b0,
                   vt[i].cls, vt[i].score, vt[i].to, vt[i].cnt);
        end

        // Randomized frames against the reference model
        for (int r = 0; r < 16; r++) begin
            d = $urandom_range(0, 70);
            for (int i = 0; i < NC; i++) begin
                if (r % 2 == 0) sc[i*DW +: DW] = pal[$urandom_range(0, 3)];
                else            sc[i*DW +: DW] = 16'($urandom);
            end
            rto = (d + 1 > TO);
            if (rto) begin
                rc = 0; rs = '0; rcnt = NP + TO;
            end else begin
                ref_argmax(sc, rc, rs);
                rcnt = NP + (d + 1) + (NC - 1);
            end
            do_run($sformatf("rand%0d", r), d, sc, 0, 1'b0, 1'($urandom_range(0, 1)), rc, rs, rto, rcnt);
        end

        // Start pulses while busy are ignored
        do_run("spam", 5, vt[0].sc, 0, 1'b1, 1'b0, 7, 16'h0300, 1'b0, 16 + 6 + 14);
        idle_check("spam", 20);

        // Reset in the middle of a burst
        start = 1'b1;
        d = 0;
        do begin
            @(negedge clk);
            d++;
            start = 1'b0;
        end while (!(mem_rd_en && mem_addr == AW'(8)) && d < 40);
        check("rst.reach_addr8", d, 9);
        check("rst.nn_en_before", nn_en, 1);
        rst = 1'b1;
        #1;
        reset_chk("rst.async");
        @(posedge clk);
        @(negedge clk);
        reset_chk("rst.held");
        rst = 1'b0;
        prev_cls = 0; prev_sc = '0; prev_cnt = 0;
        idle_check("rst", 3);
        do_run("rst.rerun", vt[0].vdelay, vt[0].sc, 0, 1'b0, 1'b0, 7, 16'h0300, 1'b0, 41);

        // Back-to-back runs with start held high
        do_run("b2b.a", vt[0].vdelay, vt[0].sc, 1, 1'b0, 1'b0, 7, 16'h0300, 1'b0, 41);
        do_run("b2b.b", vt[1].vdelay, vt[1].sc, 2, 1'b0, 1'b0, 3, 16'hFF80, 1'b0, 36);
        idle_check("b2b", 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
